// File: rtl/riscv_dbg_pkg.sv
// rtl/riscv_dbg_pkg.sv - shared types and constants for the retirement trace buffer
package riscv_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  localparam logic MODE_STOP_FULL = 1'b0;
  localparam logic MODE_RING_TRIG = 1'b1;

  // One entry packs {regs, instr, pc}
  function automatic int entry_w(input int xlen, input int num_regs);
    return xlen * (2 + num_regs);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace storage, synchronous write, asynchronous read, no reset
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 192,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/riscv_trace_buffer.sv
// rtl/riscv_trace_buffer.sv - retirement trace capture with stop-full and PC-trigger modes
module riscv_trace_buffer
  import riscv_dbg_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 4,
  parameter int DEPTH      = 16,
  parameter int POST_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          pc_dbg,
  input  logic [XLEN-1:0]          instr_dbg,
  input  logic [NUM_REGS*XLEN-1:0] regs_dbg,
  input  logic                     arm,
  input  logic                     clear,
  input  logic                     mode,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  output logic                     busy,
  output logic                     triggered,
  output logic                     wrapped,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_instr,
  output logic [NUM_REGS*XLEN-1:0] rd_regs,
  output logic                     rd_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(XLEN, NUM_REGS);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] POST_C  = CW'(POST_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  trace_state_t  state, state_n;
  logic          mode_q, mode_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0] count, count_n, post_cnt, post_cnt_n, rd_left, rd_left_n;
  logic          triggered_n, wrapped_n, first_q, first_n;
  logic [XLEN-1:0] pc_q;
  logic          cap, trig_hit, pop, go_done, we;
  logic [EW-1:0] wdata, rdata;

  assign busy     = (state == ST_ARMED) || (state == ST_POST);
  assign rd_valid = (state == ST_DONE) && (rd_left != '0);
  assign rd_last  = rd_valid && (rd_left == ONE_C);
  assign cap      = busy && (first_q || (pc_dbg != pc_q));
  assign trig_hit = (state == ST_ARMED) && (mode_q == MODE_RING_TRIG) && trig_en && (pc_dbg == trig_pc);
  assign pop      = rd_valid && rd_ready;

  always_comb begin
    state_n     = state;
    mode_n      = mode_q;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    count_n     = count;
    post_cnt_n  = post_cnt;
    rd_left_n   = rd_left;
    triggered_n = triggered;
    wrapped_n   = wrapped;
    first_n     = first_q;
    go_done     = 1'b0;
    we          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (arm) begin
          state_n     = ST_ARMED;
          mode_n      = mode;
          wr_ptr_n    = '0;
          count_n     = '0;
          triggered_n = 1'b0;
          wrapped_n   = 1'b0;
          first_n     = 1'b1;
        end
      end
      ST_ARMED, ST_POST: begin
        if (cap) begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + ONE_A;
          count_n  = (count == DEPTH_C) ? count : count + ONE_C;
          first_n  = 1'b0;
          if (count == DEPTH_C) begin
            wrapped_n = 1'b1;
          end
          if (mode_q == MODE_STOP_FULL) begin
            go_done = (count_n == DEPTH_C);
          end else if (state == ST_POST) begin
            post_cnt_n = post_cnt - ONE_C;
            go_done    = (post_cnt == ONE_C);
          end else if (trig_hit) begin
            triggered_n = 1'b1;
            if (POST_DEPTH == 0) begin
              go_done = 1'b1;
            end else begin
              state_n    = ST_POST;
              post_cnt_n = POST_C;
            end
          end
        end
      end
      ST_DONE: begin
        if (pop) begin
          rd_ptr_n  = rd_ptr + ONE_A;
          rd_left_n = rd_left - ONE_C;
          if (rd_left == ONE_C) begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Oldest entry sits count_next slots behind the next write slot
    if (go_done) begin
      state_n   = ST_DONE;
      rd_ptr_n  = wr_ptr_n - count_n[AW-1:0];
      rd_left_n = count_n;
    end

    if (clear) begin
      state_n   = ST_IDLE;
      we        = 1'b0;
      rd_left_n = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_STOP_FULL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      rd_left   <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
      first_q   <= 1'b0;
      pc_q      <= '0;
    end else begin
      state     <= state_n;
      mode_q    <= mode_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      post_cnt  <= post_cnt_n;
      rd_left   <= rd_left_n;
      triggered <= triggered_n;
      wrapped   <= wrapped_n;
      first_q   <= first_n;
      pc_q      <= pc_dbg;
    end
  end

  assign wdata = {regs_dbg, instr_dbg, pc_dbg};

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign rd_pc    = rdata[XLEN-1:0];
  assign rd_instr = rdata[2*XLEN-1:XLEN];
  assign rd_regs  = rdata[EW-1:2*XLEN];

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb/tb_riscv_trace_buffer.sv - directed self-checking bench for riscv_trace_buffer
module tb_riscv_trace_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  pc_dbg, instr_dbg, trig_pc;
  logic [127:0] regs_dbg;
  logic         arm8, arm0, clear, mode, trig_en, rdy, sel;

  logic         busy8, trig8, wrap8, valid8, last8;
  logic [31:0]  pc8, instr8;
  logic [127:0] regs8;
  logic         busy0, trig0, wrap0, valid0, last0;
  logic [31:0]  pc0, instr0;
  logic [127:0] regs0;

  logic         busy, triggered, wrapped, rd_valid, rd_last;
  logic [31:0]  rd_pc, rd_instr;
  logic [127:0] rd_regs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_trace_buffer #(.XLEN(32), .NUM_REGS(4), .DEPTH(16), .POST_DEPTH(8)) u_dut (
    .clk(clk), .reset(reset), .pc_dbg(pc_dbg), .instr_dbg(instr_dbg), .regs_dbg(regs_dbg),
    .arm(arm8), .clear(clear), .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc),
    .busy(busy8), .triggered(trig8), .wrapped(wrap8), .rd_valid(valid8), .rd_ready(rdy & ~sel),
    .rd_pc(pc8), .rd_instr(instr8), .rd_regs(regs8), .rd_last(last8)
  );

  riscv_trace_buffer #(.XLEN(32), .NUM_REGS(4), .DEPTH(16), .POST_DEPTH(0)) u_dut_p0 (
    .clk(clk), .reset(reset), .pc_dbg(pc_dbg), .instr_dbg(instr_dbg), .regs_dbg(regs_dbg),
    .arm(arm0), .clear(clear), .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc),
    .busy(busy0), .triggered(trig0), .wrapped(wrap0), .rd_valid(valid0), .rd_ready(rdy & sel),
    .rd_pc(pc0), .rd_instr(instr0), .rd_regs(regs0), .rd_last(last0)
  );

  assign busy      = sel ? busy0  : busy8;
  assign triggered = sel ? trig0  : trig8;
  assign wrapped   = sel ? wrap0  : wrap8;
  assign rd_valid  = sel ? valid0 : valid8;
  assign rd_last   = sel ? last0  : last8;
  assign rd_pc     = sel ? pc0    : pc8;
  assign rd_instr  = sel ? instr0 : instr8;
  assign rd_regs   = sel ? regs0  : regs8;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_instr(input logic [31:0] p);
    return p ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [127:0] exp_regs(input logic [31:0] p);
    return {p + 32'd4, p + 32'd3, p + 32'd2, p + 32'd1};
  endfunction

  task automatic set_pc(input logic [31:0] p);
    pc_dbg    = p;
    instr_dbg = exp_instr(p);
    regs_dbg  = exp_regs(p);
  endtask

  task automatic run_pcs(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      set_pc(first + 32'(4 * i));
      tick;
    end
  endtask

  task automatic do_arm(input logic m);
    mode = m;
    if (sel) arm0 = 1'b1;
    else     arm8 = 1'b1;
    tick;
    arm0 = 1'b0;
    arm8 = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [31:0] first, input int n, input bit toggle);
    int budget;
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      budget = 0;
      e = first + 32'(4 * i);
      while (!rd_valid && budget < 20) begin
        tick;
        budget++;
      end
      if (!rd_valid) begin
        check({tag, "_timeout"}, rd_valid, 1'b1);
        return;
      end
      if (toggle) begin
        rdy = 1'b0;
        tick;
        check({tag, "_stall_valid"}, rd_valid, 1'b1);
        check({tag, "_stall_pc"}, rd_pc, e);
      end
      check({tag, "_pc"}, rd_pc, e);
      check({tag, "_instr"}, rd_instr, exp_instr(e));
      check({tag, "_regs"}, rd_regs, exp_regs(e));
      check({tag, "_last"}, rd_last, (i == n - 1));
      rdy = 1'b1;
      tick;
      rdy = 1'b0;
    end
    check({tag, "_end_valid"}, rd_valid, 1'b0);
    check({tag, "_end_busy"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = 1'b0; arm8 = 1'b0; arm0 = 1'b0; clear = 1'b0;
    mode = 1'b0; trig_en = 1'b0; trig_pc = '0; rdy = 1'b0;
    set_pc(32'h0);
    tick; tick;
    check("rst_busy", busy8, 1'b0);
    check("rst_valid", valid8, 1'b0);
    check("rst_last", last8, 1'b0);
    check("rst_trig", trig8, 1'b0);
    check("rst_wrap", wrap8, 1'b0);
    check("rst_busy_p0", busy0, 1'b0);
    check("rst_valid_p0", valid0, 1'b0);
    reset = 1'b0;
    tick;

    // stop-when-full
    set_pc(32'h0);
    do_arm(1'b0);
    check("m0_armed", busy, 1'b1);
    run_pcs(32'h0, 20);
    check("m0_busy", busy, 1'b0);
    check("m0_valid", rd_valid, 1'b1);
    check("m0_wrap", wrapped, 1'b0);
    check("m0_trig", triggered, 1'b0);
    drain("m0", 32'h0, 16, 1'b0);

    // ring until trigger at 0x100, 8 post captures, stalled readout
    trig_pc = 32'h100;
    trig_en = 1'b1;
    set_pc(32'h0);
    do_arm(1'b1);
    run_pcs(32'h0, 30);
    check("m1_busy_mid", busy, 1'b1);
    check("m1_trig_mid", triggered, 1'b0);
    check("m1_wrap_mid", wrapped, 1'b1);
    run_pcs(32'h78, 100);
    check("m1_trig", triggered, 1'b1);
    check("m1_wrap", wrapped, 1'b1);
    check("m1_busy", busy, 1'b0);
    drain("m1", 32'hE4, 16, 1'b1);

    // PC held for 5 cycles at 0x40
    trig_en = 1'b0;
    set_pc(32'h20);
    do_arm(1'b0);
    run_pcs(32'h20, 8);
    set_pc(32'h40);
    repeat (5) tick;
    run_pcs(32'h44, 10);
    drain("hold", 32'h20, 16, 1'b0);

    // clear while in POST
    trig_en = 1'b1;
    trig_pc = 32'h100;
    set_pc(32'hF0);
    do_arm(1'b1);
    run_pcs(32'hF0, 7);
    check("post_busy", busy, 1'b1);
    check("post_trig", triggered, 1'b1);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("clr_busy", busy, 1'b0);
    check("clr_valid", rd_valid, 1'b0);

    // fresh window, then async reset mid-readout
    trig_en = 1'b0;
    set_pc(32'h300);
    do_arm(1'b0);
    run_pcs(32'h300, 16);
    check("rr_valid", rd_valid, 1'b1);
    rdy = 1'b1;
    repeat (3) tick;
    rdy = 1'b0;
    check("rr_pc", rd_pc, 32'h30C);
    #2 reset = 1'b1;
    #1;
    check("rr_rst_valid", rd_valid, 1'b0);
    check("rr_rst_busy", busy, 1'b0);
    tick;
    reset = 1'b0;
    tick;
    set_pc(32'h400);
    do_arm(1'b0);
    run_pcs(32'h400, 16);
    drain("rearm", 32'h400, 16, 1'b0);

    // POST_DEPTH == 0, trigger on the 3rd capture
    sel = 1'b1;
    trig_en = 1'b1;
    trig_pc = 32'h508;
    set_pc(32'h500);
    do_arm(1'b1);
    run_pcs(32'h500, 6);
    check("p0_trig", triggered, 1'b1);
    check("p0_wrap", wrapped, 1'b0);
    check("p0_busy", busy, 1'b0);
    drain("p0", 32'h500, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
